match_sequencer: RTL and testbench
==================================

Name: match_sequencer

Overview:
Match-level controller for the tug-of-war game. It sequences a best-of-N match as a series of rounds: arms each round, fires the round start to the master controller, and collects round outcomes. It keeps per-player round-win counts, declares the match winner and drives a display select for the LED multiplexer. It sits above the master controller and scorer, and all its timing uses the shared slowen tick.

Parameters:
WINS_NEEDED, 3, round wins required to take the match (1..15)
ARM_TICKS, 4, slowen ticks between arming and round_go
RESULT_TICKS, 8, slowen ticks the round result is shown
TIMEOUT_TICKS, 64, slowen ticks before an unresolved round is declared a tie
CNT_W, 8, width of the tick down-counter; must hold max(ARM_TICKS, RESULT_TICKS, TIMEOUT_TICKS)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
slowen  in  1  one-cycle tick enable from the clock divider
start  in  1  synchronized start request, level or pulse
round_done  in  1  one-cycle pulse: current round resolved
round_right  in  1  valid with round_done: 1 = right won, 0 = left won
round_tie  in  1  valid with round_done: tie, overrides round_right
round_go  out  1  one-cycle pulse: begin a round
match_active  out  1  high from leaving IDLE until entering MATCH_END
wins_l  out  4  left round-win count
wins_r  out  4  right round-win count
match_over  out  1  high in MATCH_END
winner_right  out  1  valid while match_over: 1 = right won the match
disp_sel  out  2  00 blank, 01 round result, 10 match scores, 11 winner flash

Behaviour:
- Reset, synchronous and active-high, is sampled on the clk rising edge.
  - Reset values: state IDLE, counter 0, all outputs 0, disp_sel 00.
  - Reset mid-operation aborts the match immediately, with no round_go afterwards.
- States: IDLE, ARM, ROUND, RESULT, MATCH_END.
- IDLE: disp_sel 00.
  - start=1 -> ARM: clear wins_l and wins_r, load counter with ARM_TICKS, match_active goes high.
- ARM: disp_sel 10.
  - Counter decrements only on cycles with slowen=1.
  - Transition on the slowen cycle where the counter equals 1, i.e. exactly ARM_TICKS slowen ticks after entry. In that cycle: go to ROUND, pulse round_go for 1 clk, load TIMEOUT_TICKS.
- ROUND: disp_sel 10.
  - round_done=1 with round_tie=1 -> no score change.
  - round_done=1 with round_tie=0 -> increment wins_r if round_right=1, otherwise wins_l.
  - Either case -> RESULT, load RESULT_TICKS.
  - Counter expiry on slowen with no round_done -> treated as a tie, RESULT.
  - round_done in the same cycle as expiry -> round_done wins; it is scored.
- RESULT: disp_sel 01.
  - On counter expiry:
    - if wins_l==WINS_NEEDED or wins_r==WINS_NEEDED -> MATCH_END, winner_right = (wins_r==WINS_NEEDED);
    - otherwise -> ARM, load ARM_TICKS.
- MATCH_END: match_over=1, match_active=0.
  - disp_sel alternates 11/10 on every slowen tick, starting at 11.
  - Win counts hold.
  - start=1 -> behaves exactly as start in IDLE.
- Win counters saturate at WINS_NEEDED and never wrap.
- Only one counter increments per round.
- Ignored inputs:
  - round_done outside ROUND, including in the round_go cycle;
  - start outside IDLE and MATCH_END;
  - slowen outside ARM, ROUND, RESULT and MATCH_END.
- round_go is never asserted in two consecutive cycles, and at most once per ARM visit.
- Latency: round_go is combinational-free (registered), asserted in the cycle after the final ARM tick is sampled. All outputs are registered.

Decomposition:
- Shared package match_pkg:
  - state encoding (IDLE, ARM, ROUND, RESULT, MATCH_END);
  - disp_sel constants DISP_BLANK, DISP_ROUND, DISP_SCORE, DISP_WIN;
  - 4-bit width constant for the win counts.
- Sub-module tick_timer:
  - loadable CNT_W down-counter gated by slowen;
  - ports clk, rst, load, load_val, slowen, expire;
  - expire is a 1-clk pulse on the slowen cycle where the count goes 1->0.
- The FSM, win counters and display logic stay in match_sequencer.

Test Plan:
- Reset, then start pulse with ARM_TICKS=4 -> round_go is a single 1-clk pulse after exactly 4 slowen ticks; match_active=1; wins_l=wins_r=0.
- Three round_done pulses with round_right=1, each after its round_go -> wins_r steps 1,2,3; after the 3rd RESULT hold, match_over=1, winner_right=1, disp_sel toggles 11/10 per slowen; wins_l=0.
- Round with round_done and round_tie=1, round_right=1 -> counts unchanged, disp_sel=01 for 8 slowen ticks, then a new round_go.
- No round_done for 64 slowen ticks -> tie, no count change. A second case drives round_done on the same cycle as expiry -> that round is scored.
- Assert rst mid-ROUND with wins_l=2 -> next cycle state IDLE, all outputs 0, and no round_go for 100 cycles even with slowen toggling.
- In MATCH_END assert start -> counts clear to 0, match_over=0, round_go after ARM_TICKS. Extra round_done pulses and start during ROUND are ignored.

Source files
------------

// File: rtl/match_pkg.sv
// match_pkg: shared definitions for the tug-of-war match sequencer.
//   state_t    - match FSM states
//   DISP_*     - disp_sel codes driven to the LED multiplexer
//   WIN_W      - width of the per-player round-win counters
package match_pkg;

   localparam int WIN_W = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      ROUND     = 3'd2,
      RESULT    = 3'd3,
      MATCH_END = 3'd4
   } state_t;

   localparam logic [1:0] DISP_BLANK = 2'b00;
   localparam logic [1:0] DISP_ROUND = 2'b01;
   localparam logic [1:0] DISP_SCORE = 2'b10;
   localparam logic [1:0] DISP_WIN   = 2'b11;

endpackage

// File: rtl/tick_timer.sv
// tick_timer: loadable down-counter that only moves on slowen ticks.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val this cycle (takes priority over counting)
//   load_val  - value to load
//   slowen    - tick enable; the count decrements on ticks while non-zero
//   expire    - 1-clk pulse on the slowen cycle where the count goes 1 -> 0
module tick_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             slowen,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (slowen && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // Combinational so the owning FSM can act in the same tick cycle.
   assign expire = slowen && (count == CNT_W'(1));

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: best-of-N match controller for the tug-of-war game.
// Arms each round, pulses round_go, scores round outcomes, declares the
// match winner and selects what the LED multiplexer shows.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   slowen        - shared slow tick enable; all match timing counts these
//   start         - start (or restart) a match from IDLE / MATCH_END
//   round_done    - pulse: round resolved; round_right / round_tie qualify it
//   round_go      - registered 1-clk pulse starting a round
//   match_active  - high while a match is in progress
//   wins_l/wins_r - round-win counts, saturating at WINS_NEEDED
//   match_over    - high in MATCH_END; winner_right names the match winner
//   disp_sel      - 00 blank, 01 round result, 10 scores, 11 winner flash
module match_sequencer
   import match_pkg::*;
#(
   parameter int unsigned WINS_NEEDED   = 3,
   parameter int unsigned ARM_TICKS     = 4,
   parameter int unsigned RESULT_TICKS  = 8,
   parameter int unsigned TIMEOUT_TICKS = 64,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             slowen,
   input  logic             start,
   input  logic             round_done,
   input  logic             round_right,
   input  logic             round_tie,
   output logic             round_go,
   output logic             match_active,
   output logic [WIN_W-1:0] wins_l,
   output logic [WIN_W-1:0] wins_r,
   output logic             match_over,
   output logic             winner_right,
   output logic [1:0]       disp_sel
);

   localparam logic [WIN_W-1:0] WIN_TGT   = WIN_W'(WINS_NEEDED);
   localparam logic [CNT_W-1:0] ARM_V     = CNT_W'(ARM_TICKS);
   localparam logic [CNT_W-1:0] RESULT_V  = CNT_W'(RESULT_TICKS);
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_TICKS);

   state_t           state, state_d;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             expire;

   logic             round_go_d, match_active_d, match_over_d, winner_right_d;
   logic [WIN_W-1:0] wins_l_d, wins_r_d;
   logic [1:0]       disp_sel_d;
   logic             accept_done;
   logic             new_match;

   tick_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .slowen   (slowen),
      .expire   (expire)
   );

   // round_done is ignored in the round_go cycle (round not yet under way).
   assign accept_done = (state == ROUND) && round_done && !round_go;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         round_go     <= 1'b0;
         match_active <= 1'b0;
         match_over   <= 1'b0;
         winner_right <= 1'b0;
         wins_l       <= '0;
         wins_r       <= '0;
         disp_sel     <= DISP_BLANK;
      end else begin
         state        <= state_d;
         round_go     <= round_go_d;
         match_active <= match_active_d;
         match_over   <= match_over_d;
         winner_right <= winner_right_d;
         wins_l       <= wins_l_d;
         wins_r       <= wins_r_d;
         disp_sel     <= disp_sel_d;
      end
   end

   // Next state and timer loads.
   always_comb begin
      state_d  = state;
      load     = 1'b0;
      load_val = '0;
      case (state)
         IDLE, MATCH_END: begin
            if (start) begin
               state_d  = ARM;
               load     = 1'b1;
               load_val = ARM_V;
            end
         end
         ARM: begin
            if (expire) begin
               state_d  = ROUND;
               load     = 1'b1;
               load_val = TIMEOUT_V;
            end
         end
         ROUND: begin
            // A round_done coinciding with timeout is scored below, not tied.
            if (accept_done || expire) begin
               state_d  = RESULT;
               load     = 1'b1;
               load_val = RESULT_V;
            end
         end
         RESULT: begin
            if (expire) begin
               if ((wins_l == WIN_TGT) || (wins_r == WIN_TGT)) begin
                  state_d = MATCH_END;
               end else begin
                  state_d  = ARM;
                  load     = 1'b1;
                  load_val = ARM_V;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, decoded from the transition.
   always_comb begin
      new_match      = ((state == IDLE) || (state == MATCH_END)) && (state_d == ARM);
      round_go_d     = (state == ARM) && (state_d == ROUND);
      match_active_d = (state_d == ARM) || (state_d == ROUND) || (state_d == RESULT);
      match_over_d   = (state_d == MATCH_END);

      wins_l_d = wins_l;
      wins_r_d = wins_r;
      if (new_match) begin
         wins_l_d = '0;
         wins_r_d = '0;
      end else if (accept_done && !round_tie) begin
         if (round_right) begin
            if (wins_r < WIN_TGT) wins_r_d = wins_r + 1'b1;
         end else begin
            if (wins_l < WIN_TGT) wins_l_d = wins_l + 1'b1;
         end
      end

      winner_right_d = winner_right;
      if (new_match) begin
         winner_right_d = 1'b0;
      end else if ((state == RESULT) && (state_d == MATCH_END)) begin
         winner_right_d = (wins_r == WIN_TGT);
      end

      disp_sel_d = DISP_BLANK;
      case (state_d)
         IDLE:       disp_sel_d = DISP_BLANK;
         ARM, ROUND: disp_sel_d = DISP_SCORE;
         RESULT:     disp_sel_d = DISP_ROUND;
         MATCH_END: begin
            // Enter on the winner flash, then swap 11 <-> 10 each tick.
            if (state != MATCH_END)  disp_sel_d = DISP_WIN;
            else if (slowen)         disp_sel_d = disp_sel ^ 2'b01;
            else                     disp_sel_d = disp_sel;
         end
         default:    disp_sel_d = DISP_BLANK;
      endcase
   end

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed bench for match_sequencer with a per-cycle
// behavioural match model and hand-computed literal expectations.
module tb_match_sequencer;

   localparam int N      = 3;
   localparam int ARM_T  = 4;
   localparam int RES_T  = 8;
   localparam int TO_T   = 64;

   // Model phases of a match.
   localparam int P_IDLE = 0;
   localparam int P_ARM  = 1;
   localparam int P_PLAY = 2;
   localparam int P_SHOW = 3;
   localparam int P_OVER = 4;

   logic       clk = 1'b0;
   logic       rst, slowen, start, round_done, round_right, round_tie;
   logic       round_go, match_active, match_over, winner_right;
   logic [3:0] wins_l, wins_r;
   logic [1:0] disp_sel;

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset block ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   match_sequencer #(
      .WINS_NEEDED(N), .ARM_TICKS(ARM_T), .RESULT_TICKS(RES_T),
      .TIMEOUT_TICKS(TO_T), .CNT_W(8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .slowen       (slowen),
      .start        (start),
      .round_done   (round_done),
      .round_right  (round_right),
      .round_tie    (round_tie),
      .round_go     (round_go),
      .match_active (match_active),
      .wins_l       (wins_l),
      .wins_r       (wins_r),
      .match_over   (match_over),
      .winner_right (winner_right),
      .disp_sel     (disp_sel)
   );

   // slowen: one tick every 4 clocks, changed on the falling edge.
   initial begin
      int div;
      div    = 0;
      slowen = 1'b0;
      forever begin
         @(negedge clk);
         div++;
         slowen = ((div % 4) == 0);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_phase = P_IDLE;
   int m_left  = 0;
   int m_flash = 0;
   int m_wl    = 0;
   int m_wr    = 0;
   bit m_win   = 1'b0;
   bit m_go    = 1'b0;

   task automatic model_step();
      bit go_n;
      go_n = 1'b0;
      if (rst) begin
         m_phase = P_IDLE; m_left = 0; m_flash = 0;
         m_wl = 0; m_wr = 0; m_win = 1'b0;
      end else begin
         case (m_phase)
            P_IDLE, P_OVER: begin
               if (start) begin
                  m_phase = P_ARM; m_left = ARM_T;
                  m_wl = 0; m_wr = 0; m_win = 1'b0;
               end else if (m_phase == P_OVER && slowen) begin
                  m_flash++;
               end
            end
            P_ARM: begin
               if (slowen) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase = P_PLAY; m_left = TO_T; go_n = 1'b1;
                  end
               end
            end
            P_PLAY: begin
               if (round_done && !m_go) begin
                  if (!round_tie) begin
                     if (round_right) m_wr = (m_wr < N) ? m_wr + 1 : m_wr;
                     else             m_wl = (m_wl < N) ? m_wl + 1 : m_wl;
                  end
                  m_phase = P_SHOW; m_left = RES_T;
               end else if (slowen) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase = P_SHOW; m_left = RES_T;
                  end
               end
            end
            P_SHOW: begin
               if (slowen) begin
                  m_left--;
                  if (m_left == 0) begin
                     if (m_wl == N || m_wr == N) begin
                        m_phase = P_OVER; m_win = (m_wr == N); m_flash = 0;
                     end else begin
                        m_phase = P_ARM; m_left = ARM_T;
                     end
                  end
               end
            end
            default: m_phase = P_IDLE;
         endcase
      end
      m_go = go_n;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   function automatic int exp_disp();
      case (m_phase)
         P_ARM, P_PLAY: return 2;
         P_SHOW:        return 1;
         P_OVER:        return ((m_flash % 2) == 0) ? 3 : 2;
         default:       return 0;
      endcase
   endfunction

   // Compare process: every cycle, outputs against the model.
   initial forever begin
      @(negedge clk);
      check("cmp_round_go",     round_go,     m_go);
      check("cmp_match_active", match_active, (m_phase >= P_ARM && m_phase <= P_SHOW));
      check("cmp_match_over",   match_over,   m_phase == P_OVER);
      check("cmp_winner_right", winner_right, m_win);
      check("cmp_wins_l",       wins_l,       m_wl);
      check("cmp_wins_r",       wins_r,       m_wr);
      check("cmp_disp_sel",     disp_sel,     exp_disp());
   end

   // ---------------- driver tasks ----------------
   task automatic next_cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      next_cyc();
      start = 1'b1;
      next_cyc();
      start = 1'b0;
   endtask

   // Returns positioned in the round_go cycle; ticks counts slowen seen before it.
   task automatic wait_go(input string name, input int budget, output int ticks);
      bit seen;
      ticks = 0;
      seen  = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (round_go) begin
            seen = 1'b1;
            break;
         end
         if (slowen) ticks++;
         next_cyc();
      end
      check({name, "_go_seen"}, seen, 1);
   endtask

   task automatic send_done(input bit right, input bit tie);
      round_done  = 1'b1;
      round_right = right;
      round_tie   = tie;
      next_cyc();
      round_done  = 1'b0;
      round_right = 1'b0;
      round_tie   = 1'b0;
   endtask

   task automatic wait_over(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (match_over) begin
            seen = 1'b1;
            break;
         end
         next_cyc();
      end
      check("match_over_seen", seen, 1);
   endtask

   task automatic wait_slow_tick();
      for (int i = 0; i < 8; i++) begin
         if (slowen) break;
         next_cyc();
      end
      next_cyc();
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int t;
      int n;
      int go_cnt;
      rst = 1'b1; start = 1'b0; round_done = 1'b0;
      round_right = 1'b0; round_tie = 1'b0;
      repeat (3) next_cyc();
      rst = 1'b0;
      next_cyc();
      check("reset_round_go", round_go, 0);
      check("reset_active",   match_active, 0);
      check("reset_over",     match_over, 0);
      check("reset_disp",     disp_sel, 0);

      // Match A: right wins 3-0 with a tie and a timeout along the way.
      pulse_start();
      wait_go("first", 100, t);
      check("first_arm_ticks", t, 4);
      check("first_active", match_active, 1);
      check("first_wins", {wins_l, wins_r}, 0);
      next_cyc();
      check("go_single_pulse", round_go, 0);

      repeat (3) next_cyc();
      send_done(1'b1, 1'b0);
      check("r1_wins_r", wins_r, 1);
      check("r1_disp", disp_sel, 1);
      next_cyc();
      send_done(1'b0, 1'b0);            // outside ROUND: ignored
      check("r1_extra_done_wins_l", wins_l, 0);
      wait_go("r2", 200, t);

      send_done(1'b1, 1'b0);            // in the round_go cycle: ignored
      check("r2_go_cycle_done_ignored", wins_r, 1);
      check("r2_still_round", disp_sel, 2);
      start = 1'b1;
      next_cyc();
      start = 1'b0;
      check("r2_start_ignored", match_active, 1);
      send_done(1'b1, 1'b1);            // tie overrides right
      check("r2_tie_wins_r", wins_r, 1);
      check("r2_tie_wins_l", wins_l, 0);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (disp_sel != 2'b01) break;
         if (slowen) n++;
         next_cyc();
      end
      check("r2_result_ticks", n, 8);
      wait_go("r3", 200, t);

      repeat (2) next_cyc();
      send_done(1'b1, 1'b0);
      check("r3_wins_r", wins_r, 2);
      wait_go("r4", 200, t);

      n = 0;                            // timeout round, no round_done
      for (int i = 0; i < 400; i++) begin
         if (disp_sel == 2'b01) break;
         if (slowen) n++;
         next_cyc();
      end
      check("r4_timeout_ticks", n, 64);
      check("r4_timeout_wins_r", wins_r, 2);
      check("r4_timeout_wins_l", wins_l, 0);
      wait_go("r5", 200, t);

      repeat (5) next_cyc();
      send_done(1'b1, 1'b0);
      check("r5_wins_r", wins_r, 3);
      wait_over(200);
      check("end_winner_right", winner_right, 1);
      check("end_wins_l", wins_l, 0);
      check("end_wins_r", wins_r, 3);
      check("end_active", match_active, 0);
      check("end_disp_first", disp_sel, 3);
      wait_slow_tick();
      check("end_disp_toggle1", disp_sel, 2);
      wait_slow_tick();
      check("end_disp_toggle2", disp_sel, 3);

      // Match B: restart from MATCH_END, left scores, then reset mid-round.
      pulse_start();
      check("restart_wins", {wins_l, wins_r}, 0);
      check("restart_over", match_over, 0);
      check("restart_winner", winner_right, 0);
      wait_go("b1", 100, t);
      check("b1_arm_ticks", t, 4);
      next_cyc();
      send_done(1'b0, 1'b0);
      check("b1_wins_l", wins_l, 1);
      wait_go("b2", 200, t);

      n = 0;                            // round_done on the expiry tick
      for (int i = 0; i < 400; i++) begin
         if (slowen) n++;
         if (n == 64) break;
         next_cyc();
      end
      send_done(1'b0, 1'b0);
      check("b2_expiry_scored", wins_l, 2);
      check("b2_disp", disp_sel, 1);
      wait_go("b3", 200, t);

      repeat (6) next_cyc();
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      check("rst_wins_l", wins_l, 0);
      check("rst_active", match_active, 0);
      check("rst_disp", disp_sel, 0);
      go_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (round_go) go_cnt++;
         next_cyc();
      end
      check("rst_no_round_go", go_cnt, 0);

      pulse_start();
      wait_go("after_rst", 100, t);
      check("after_rst_arm_ticks", t, 4);
      repeat (2) next_cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
